i2c_slave_reg_ctrl: RTL and testbench
=====================================

I2C_SLAVE_REG_CTRL -- requirements
Module: i2c_slave_reg_ctrl

Interface
REQ-001 SHALL have clk, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have rst_n, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have ctrl_en, input, 1, block enable; also drives the slave enable.
REQ-004 SHALL have slave_en, output, 1, I2C slave enable; equals ctrl_en registered.
REQ-005 SHALL have rd_reg_full, input, 1, slave has a received byte ready.
REQ-006 SHALL have rx_byte, input, 8, received byte from the slave.
REQ-007 SHALL have rd_clr, output, 1, one-cycle pulse: received byte consumed.
REQ-008 SHALL have wr_reg_empty, input, 1, slave transmit register empty.
REQ-009 SHALL have tx_byte, output, 8, byte offered to the slave.
REQ-010 SHALL have wr_rdy, output, 1, one-cycle pulse: tx_byte valid.
REQ-011 SHALL have addr_match, input, 1, one-cycle address-match pulse from the slave.
REQ-012 SHALL have trans_dir, input, 1, valid the cycle after addr_match; 1 = slave receives, 0 = slave transmits.
REQ-013 SHALL have trans_stop and bus_err, inputs, 1 each, transaction-end indications.
REQ-014 SHALL have host_we, host_addr[3:0], host_wdata[7:0], inputs, host register-file write port.
REQ-015 SHALL have host_rdata, output, 8, reg[host_addr], registered, 1-cycle latency.
REQ-016 SHALL have i2c_wr_strb (1) and i2c_wr_addr (4), outputs, one-cycle pulse and index per I2C register write.
REQ-017 SHALL have host_conflict (1), output, one-cycle pulse when a host write is dropped.
REQ-018 SHALL have busy (1) and ptr (4), outputs, transaction active and current register pointer.

Function
REQ-019 SHALL contain a 16 x 8 register file and a 4-bit pointer; pointer increments wrap 15 -> 0.
REQ-020 SHALL implement FSM states IDLE, ADDR_WAIT, DIR, RX_PTR, RX_DATA, TX.
REQ-021 IDLE -> ADDR_WAIT when ctrl_en=1; any state -> IDLE when ctrl_en=0, with the register file retained.
REQ-022 ADDR_WAIT -> DIR on addr_match; DIR samples trans_dir: 1 -> RX_PTR, 0 -> TX.
REQ-023 addr_match in any non-IDLE state SHALL restart the sequence: next state DIR (repeated start).
REQ-024 trans_stop or bus_err in RX_PTR, RX_DATA or TX SHALL go to ADDR_WAIT; addr_match takes priority when simultaneous.
REQ-025 busy SHALL be 1 in DIR, RX_PTR, RX_DATA and TX, and 0 otherwise.
REQ-026 Receive consume, in RX_PTR and RX_DATA: when rd_reg_full=1 and the consume guard is clear, latch rx_byte, pulse rd_clr for 1 cycle, and set the guard. The guard SHALL clear when rd_reg_full=0 is observed. A byte SHALL never be consumed twice.
REQ-027 RX_PTR: ptr <= rx_byte[3:0] (bits 7:4 ignored), then -> RX_DATA.
REQ-028 RX_DATA: reg[ptr] <= rx_byte; pulse i2c_wr_strb with i2c_wr_addr=ptr in the same cycle; then ptr++.
REQ-029 TX entry: in the first TX cycle, drive tx_byte=reg[ptr], pulse wr_rdy and ptr++, regardless of wr_reg_empty. This overwrites any stale byte from a prior transaction. The first wr_rdy SHALL occur within 3 clk of addr_match.
REQ-030 TX steady state: on each wr_reg_empty 0->1 transition, load reg[ptr], pulse wr_rdy and ptr++. At most one load SHALL occur per empty transition.
REQ-031 Pointer semantics: ptr counts bytes loaded, so after an N-byte master read ptr = start+N+1 mod 16.
REQ-032 Host write to reg[host_addr] on host_we. If an I2C write targets the same index in the same cycle, the I2C write SHALL win and host_conflict SHALL pulse. Writes to different indices SHALL both take effect.
REQ-033 rd_reg_full SHALL be ignored in TX, and wr_reg_empty ignored in RX states.
REQ-034 rd_clr and wr_rdy SHALL never be asserted in the same cycle.

Reset
REQ-035 On rst_n=0: FSM=IDLE; ptr=0; register file all 0x00; all outputs 0 (tx_byte=0x00, host_rdata=0x00); consume guard clear.
REQ-036 Reset mid-transaction SHALL abort immediately with no rd_clr/wr_rdy pulse; after release the FSM resumes at IDLE.

Verification
REQ-037 Write: addr_match, trans_dir=1, bytes 0x03,0xA5,0x5A -> reg[3]=0xA5, reg[4]=0x5A, ptr=5, two i2c_wr_strb pulses (addr 3, then 4), three rd_clr pulses.
REQ-038 Read: reg[15]=0x11, reg[0]=0x22, ptr=15, addr_match with trans_dir=0 -> wr_rdy with tx_byte=0x11 within 3 clk; on empty 0->1, tx_byte=0x22 (wrap); ptr=1.
REQ-039 rd_reg_full held high for 5 cycles -> exactly one rd_clr pulse.
REQ-040 host_we to index 4 with 0x77 while I2C writes 0x99 to index 4 -> reg[4]=0x99 and one host_conflict pulse. Host write to a different index in the same cycle -> both written.
REQ-041 Repeated start: addr_match during RX_DATA, then trans_dir=0 -> next state DIR then TX, with wr_rdy issued.
REQ-042 ctrl_en=0 mid-TX -> IDLE next cycle; busy=0; slave_en=0 one cycle later; register contents preserved.

Source files
------------

// File: rtl/i2c_slave_reg_ctrl.sv
// Register-file controller sitting behind an I2C slave: the first received byte sets the
// pointer, further bytes write the register file, and master reads stream it out.
module i2c_slave_reg_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ctrl_en,
    output logic       slave_en,
    input  logic       rd_reg_full,
    input  logic [7:0] rx_byte,
    output logic       rd_clr,
    input  logic       wr_reg_empty,
    output logic [7:0] tx_byte,
    output logic       wr_rdy,
    input  logic       addr_match,
    input  logic       trans_dir,
    input  logic       trans_stop,
    input  logic       bus_err,
    input  logic       host_we,
    input  logic [3:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       i2c_wr_strb,
    output logic [3:0] i2c_wr_addr,
    output logic       host_conflict,
    output logic       busy,
    output logic [3:0] ptr
);

    typedef enum logic [2:0] {
        StIdle, StAddrWait, StDir, StRxPtr, StRxData, StTx
    } state_e;

    state_e     state;
    logic [7:0] regs [16];
    logic       guard;
    logic       empty_q;

    logic in_rx, consume, i2c_wr, tx_entry, tx_edge, tx_load, conflict, host_ok;

    assign in_rx    = (state == StRxPtr) || (state == StRxData);
    assign consume  = ctrl_en && in_rx && rd_reg_full && !guard;
    assign i2c_wr   = consume && (state == StRxData);
    // Prefetch on the Dir->Tx edge so wr_rdy is already high in the first TX cycle.
    assign tx_entry = ctrl_en && (state == StDir) && !addr_match && !trans_dir;
    assign tx_edge  = ctrl_en && (state == StTx) && wr_reg_empty && !empty_q;
    assign tx_load  = tx_entry || tx_edge;
    assign conflict = host_we && i2c_wr && (host_addr == ptr);
    assign host_ok  = host_we && !conflict;
    assign busy     = (state == StDir) || in_rx || (state == StTx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            ptr           <= 4'd0;
            guard         <= 1'b0;
            empty_q       <= 1'b0;
            slave_en      <= 1'b0;
            rd_clr        <= 1'b0;
            wr_rdy        <= 1'b0;
            tx_byte       <= 8'h00;
            host_rdata    <= 8'h00;
            i2c_wr_strb   <= 1'b0;
            i2c_wr_addr   <= 4'd0;
            host_conflict <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            slave_en      <= ctrl_en;
            rd_clr        <= consume;
            wr_rdy        <= tx_load;
            i2c_wr_strb   <= i2c_wr;
            host_conflict <= conflict;
            empty_q       <= wr_reg_empty;
            host_rdata    <= regs[host_addr];

            // Guard blocks re-consuming a byte until the slave drops rd_reg_full.
            if (consume) begin
                guard <= 1'b1;
            end else if (!rd_reg_full) begin
                guard <= 1'b0;
            end

            if (i2c_wr) begin
                regs[ptr]   <= rx_byte;
                i2c_wr_addr <= ptr;
            end
            if (host_ok) begin
                regs[host_addr] <= host_wdata;
            end

            if (tx_load) begin
                tx_byte <= regs[ptr];
            end
            if (consume && (state == StRxPtr)) begin
                ptr <= rx_byte[3:0];
            end else if (i2c_wr || tx_load) begin
                ptr <= ptr + 4'd1;
            end

            if (!ctrl_en) begin
                state <= StIdle;
            end else if (state == StIdle) begin
                state <= StAddrWait;
            end else if (addr_match) begin
                state <= StDir;
            end else begin
                case (state)
                    StDir: state <= trans_dir ? StRxPtr : StTx;
                    StRxPtr: begin
                        if (trans_stop || bus_err) begin
                            state <= StAddrWait;
                        end else if (consume) begin
                            state <= StRxData;
                        end
                    end
                    StRxData, StTx: begin
                        if (trans_stop || bus_err) begin
                            state <= StAddrWait;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Directed and randomized bench for i2c_slave_reg_ctrl against a register-array model.
module tb_i2c_slave_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ctrl_en = 1'b0;
    logic       rd_reg_full = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       wr_reg_empty = 1'b0;
    logic       addr_match = 1'b0;
    logic       trans_dir = 1'b0;
    logic       trans_stop = 1'b0;
    logic       bus_err = 1'b0;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = 4'd0;
    logic [7:0] host_wdata = 8'h00;

    logic       slave_en, rd_clr, wr_rdy, i2c_wr_strb, host_conflict, busy;
    logic [7:0] tx_byte, host_rdata;
    logic [3:0] i2c_wr_addr, ptr;

    i2c_slave_reg_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_en      (ctrl_en),
        .slave_en     (slave_en),
        .rd_reg_full  (rd_reg_full),
        .rx_byte      (rx_byte),
        .rd_clr       (rd_clr),
        .wr_reg_empty (wr_reg_empty),
        .tx_byte      (tx_byte),
        .wr_rdy       (wr_rdy),
        .addr_match   (addr_match),
        .trans_dir    (trans_dir),
        .trans_stop   (trans_stop),
        .bus_err      (bus_err),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .i2c_wr_strb  (i2c_wr_strb),
        .i2c_wr_addr  (i2c_wr_addr),
        .host_conflict(host_conflict),
        .busy         (busy),
        .ptr          (ptr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_rdclr = 0, n_wrrdy = 0, n_strb = 0, n_conf = 0, n_overlap = 0;
    logic [3:0] strb_q[$];

    // Reference model: register contents and pointer.
    logic [7:0] mregs [16];
    int         mptr = 0;
    logic [7:0] wdat [4];

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_clr) n_rdclr++;
            if (wr_rdy) n_wrrdy++;
            if (host_conflict) n_conf++;
            if (rd_clr && wr_rdy) n_overlap++;
            if (i2c_wr_strb) begin
                n_strb++;
                strb_q.push_back(i2c_wr_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        step();
        host_we = 1'b0;
        mregs[a] = d;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a);
        host_addr = a;
        step();
        check(tag, host_rdata, mregs[a]);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic hw, input logic [3:0] ha,
                           input logic [7:0] hd);
        logic got;
        rx_byte = b; rd_reg_full = 1'b1;
        if (hw) begin
            host_we = 1'b1; host_addr = ha; host_wdata = hd;
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            host_we = 1'b0;
            if (rd_clr) got = 1'b1;
        end
        check("rx_consumed", got, 1);
        rd_reg_full = 1'b0;
        step();
    endtask

    task automatic start_write(input logic [7:0] pb);
        addr_match = 1'b1;
        step();
        addr_match = 1'b0; trans_dir = 1'b1;
        step();
        trans_dir = 1'b0;
        check("busy_in_rx", busy, 1);
        send_rx(pb, 1'b0, 4'd0, 8'h00);
        mptr = pb % 16;
    endtask

    task automatic stop_txn();
        trans_stop = 1'b1;
        step();
        trans_stop = 1'b0;
        check("busy_after_stop", busy, 0);
    endtask

    task automatic wr_txn(input logic [7:0] pb, input int n);
        int s0;
        s0 = n_strb;
        start_write(pb);
        for (int i = 0; i < n; i++) begin
            send_rx(wdat[i], 1'b0, 4'd0, 8'h00);
            mregs[mptr] = wdat[i];
            mptr = (mptr + 1) % 16;
        end
        check("wr_strb_count", n_strb - s0, n);
        check("wr_ptr", {28'd0, ptr}, mptr);
        stop_txn();
    endtask

    task automatic rd_txn(input int k);
        addr_match = 1'b1;
        step();
        addr_match = 1'b0; trans_dir = 1'b0;
        step();
        check("rd_first_wr_rdy", wr_rdy, 1);
        check("rd_first_byte", tx_byte, mregs[mptr]);
        mptr = (mptr + 1) % 16;
        for (int i = 0; i < k; i++) begin
            wr_reg_empty = 1'b1;
            step();
            check("rd_wr_rdy", wr_rdy, 1);
            check("rd_byte", tx_byte, mregs[mptr]);
            mptr = (mptr + 1) % 16;
            wr_reg_empty = 1'b0;
            step();
            check("rd_single_load", wr_rdy, 0);
        end
        check("rd_ptr", {28'd0, ptr}, mptr);
        stop_txn();
    endtask

    initial begin
        int s_clr, s_conf;
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_slave_en", slave_en, 0);
        check("rst_rd_clr", rd_clr, 0);
        check("rst_wr_rdy", wr_rdy, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_host_rdata", host_rdata, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_ptr", ptr, 4'd0);
        check("rst_strb", i2c_wr_strb, 0);
        rst_n = 1'b1;
        ctrl_en = 1'b1;
        step();
        check("en_slave_en", slave_en, 1);
        check("en_busy", busy, 0);

        // Write 0x03, 0xA5, 0x5A
        s_clr = n_rdclr;
        strb_q.delete();
        wdat[0] = 8'hA5; wdat[1] = 8'h5A;
        wr_txn(8'h03, 2);
        check("w37_rdclr", n_rdclr - s_clr, 3);
        check("w37_strb_n", strb_q.size(), 2);
        check("w37_strb0", strb_q[0], 4'd3);
        check("w37_strb1", strb_q[1], 4'd4);
        check("w37_ptr", ptr, 4'd5);
        check_reg("w37_reg3", 4'd3);
        check("w37_reg3_const", host_rdata, 8'hA5);
        check_reg("w37_reg4", 4'd4);
        check("w37_reg4_const", host_rdata, 8'h5A);

        // rd_reg_full held for 5 cycles -> one consume
        start_write(8'h08);
        s_clr = n_rdclr;
        rx_byte = 8'h3C; rd_reg_full = 1'b1;
        repeat (5) step();
        rd_reg_full = 1'b0;
        step();
        check("hold_one_rdclr", n_rdclr - s_clr, 1);
        mregs[8] = 8'h3C; mptr = 9;
        check("hold_ptr", ptr, 4'd9);
        stop_txn();
        check_reg("hold_reg8", 4'd8);

        // Host/I2C same-index conflict, then different indices
        start_write(8'h04);
        s_conf = n_conf;
        send_rx(8'h99, 1'b1, 4'd4, 8'h77);
        mregs[4] = 8'h99; mptr = 5;
        check("conf_pulse", n_conf - s_conf, 1);
        send_rx(8'h44, 1'b1, 4'd10, 8'h66);
        mregs[5] = 8'h44; mregs[10] = 8'h66; mptr = 6;
        check("noconf_pulse", n_conf - s_conf, 1);
        stop_txn();
        check_reg("conf_reg4", 4'd4);
        check("conf_reg4_const", host_rdata, 8'h99);
        check_reg("both_reg5", 4'd5);
        check_reg("both_reg10", 4'd10);
        check("both_reg10_const", host_rdata, 8'h66);

        // Read with pointer wrap
        host_write(4'd15, 8'h11);
        host_write(4'd0, 8'h22);
        wr_txn(8'h0F, 0);
        rd_txn(1);
        check("wrap_ptr", ptr, 4'd1);

        // Repeated start from RX_DATA into TX, then disable mid-TX
        start_write(8'h02);
        send_rx(8'hC3, 1'b0, 4'd0, 8'h00);
        mregs[2] = 8'hC3; mptr = 3;
        addr_match = 1'b1;
        step();
        addr_match = 1'b0; trans_dir = 1'b0;
        check("rs_busy_dir", busy, 1);
        step();
        check("rs_wr_rdy", wr_rdy, 1);
        check("rs_tx_byte", tx_byte, mregs[3]);
        mptr = 4;
        ctrl_en = 1'b0;
        step();
        check("dis_busy", busy, 0);
        check("dis_slave_en", slave_en, 0);
        check("dis_ptr", ptr, 4'd4);
        ctrl_en = 1'b1;
        step();
        check("reen_slave_en", slave_en, 1);
        check_reg("dis_reg2", 4'd2);
        check("dis_reg2_const", host_rdata, 8'hC3);

        // Randomized transactions against the model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    for (int i = 0; i < 4; i++) wdat[i] = 8'($urandom);
                    wr_txn(8'($urandom), int'($urandom_range(0, 4)));
                end
                1: rd_txn(int'($urandom_range(0, 3)));
                default: host_write(4'($urandom), 8'($urandom));
            endcase
        end
        for (int i = 0; i < 16; i++) check_reg("rand_reg", 4'(i));

        // Reset mid-transaction aborts without a pulse
        start_write(8'h06);
        s_clr = n_rdclr;
        rx_byte = 8'h5E; rd_reg_full = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mrst_rd_clr", rd_clr, 0);
        check("mrst_wr_rdy", wr_rdy, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ptr", ptr, 4'd0);
        rd_reg_full = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mptr = 0;
        step();
        check("mrst_no_pulse", n_rdclr - s_clr, 0);
        check("mrst_idle_busy", busy, 0);
        check_reg("mrst_reg6", 4'd6);
        check_reg("mrst_reg4", 4'd4);

        check("no_rdclr_wrrdy_overlap", n_overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
